// File: rtl/bridge_reg_responder_pkg.sv
// Shared constants, types and helpers for the bridge register responder.
//   BRIDGE_WORD_BYTES : bytes per bridge word (register stride)
//   bridge_reg_idx_t  : register index, wide enough for up to 64 registers
//   bswap32()         : byte-order reversal between the bridge and the core
package bridge_reg_responder_pkg;

    localparam int BRIDGE_WORD_BYTES = 4;

    typedef logic [5:0] bridge_reg_idx_t;

    function automatic logic [31:0] bswap32(input logic [31:0] d);
        logic [31:0] r;
        for (int b = 0; b < BRIDGE_WORD_BYTES; b++) begin
            r[8*b +: 8] = d[8*(BRIDGE_WORD_BYTES-1-b) +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/bridge_rd_pipe.sv
// Read-return delay line for the bridge register responder.
// Carries a (valid, data) pair LATENCY cycles; the last stage is a hold
// register so rd_data keeps the most recent completed read.
// Ports:
//   clk, reset : clock and synchronous active-high clear (drops in-flight reads)
//   in_vld     : a read was issued and its snapshot is on in_data this cycle
//   in_data    : read snapshot (already zero on miss, already byte-ordered)
//   rd_data    : registered read return
module bridge_rd_pipe #(
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_vld,
    input  logic [31:0] in_data,
    output logic [31:0] rd_data
);

    logic [31:0] rd_data_q, rd_data_d;

    if (LATENCY == 1) begin : g_direct
        always_comb begin
            rd_data_d = in_vld ? in_data : rd_data_q;
        end
    end else begin : g_delay
        logic [LATENCY-1:1]        vld_pipe_q, vld_pipe_d;
        logic [LATENCY-1:1][31:0]  dat_pipe_q, dat_pipe_d;
        logic [LATENCY-1:0]        vld_chain;
        logic [LATENCY-1:0][31:0]  dat_chain;

        always_comb begin
            // Index 0 of the chain is the incoming read; index k is stage k.
            vld_chain  = {vld_pipe_q, in_vld};
            dat_chain  = {dat_pipe_q, in_data};
            vld_pipe_d = vld_chain[LATENCY-2:0];
            dat_pipe_d = dat_chain[LATENCY-2:0];
            rd_data_d  = vld_chain[LATENCY-1] ? dat_chain[LATENCY-1] : rd_data_q;
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                vld_pipe_q <= '0;
                dat_pipe_q <= '0;
            end else begin
                vld_pipe_q <= vld_pipe_d;
                dat_pipe_q <= dat_pipe_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) rd_data_q <= '0;
        else       rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/bridge_reg_responder.sv
// Bridge slave terminating APF bridge accesses onto a register bank.
// Registers 0..NUM_REGS-2 are RW control words, register NUM_REGS-1 is a
// W1C sticky status word fed by core event pulses. rd_data is zero on a
// miss so several slaves can be OR-combined.
// Optional build macro BRIDGE_REG_RESPONDER_ERR_COUNT_EN adds an 8-bit
// saturating count of misaligned in-window accesses, readable (and cleared
// by any write) at BASE_ADDR + 4*NUM_REGS.
// Ports:
//   clk, reset               : clock, synchronous active-high reset
//   bridge_addr/wr_data/wr/rd/endian_little : bridge request (slave end)
//   bridge_rd_data           : read return, READ_LATENCY after rd
//   ctrl_q                   : control register values
//   wr_strobe                : per control register, high the cycle it updates
//   status_set               : per-bit set pulses into the status register
//   status_q                 : status register value
module bridge_reg_responder
    import bridge_reg_responder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          NUM_REGS     = 8,
    parameter int          READ_LATENCY = 1,
    parameter logic [31:0] CTRL_RESET   = 32'h0000_0000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [31:0]                  bridge_addr,
    input  logic [31:0]                  bridge_wr_data,
    input  logic                         bridge_wr,
    input  logic                         bridge_rd,
    input  logic                         bridge_endian_little,
    output logic [31:0]                  bridge_rd_data,
    output logic [NUM_REGS-2:0][31:0]    ctrl_q,
    output logic [NUM_REGS-2:0]          wr_strobe,
    input  logic [31:0]                  status_set,
    output logic [31:0]                  status_q
);

`ifdef BRIDGE_REG_RESPONDER_ERR_COUNT_EN
    localparam int NUM_WORDS = NUM_REGS + 1;
`else
    localparam int NUM_WORDS = NUM_REGS;
`endif
    localparam logic [31:0] WIN_BYTES = 32'(BRIDGE_WORD_BYTES * NUM_WORDS);

    // Request stage: the bridge is sampled here, all effects land one edge later.
    logic        req_wr_q, req_wr_d;
    logic        req_rd_q, req_rd_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] req_data_q, req_data_d;
    logic        req_le_q, req_le_d;
    // status_set rides with the request so a set and a W1C clear issued in
    // the same cycle meet in the same update and the set wins.
    logic [31:0] status_set_q, status_set_d;

    logic [NUM_REGS-2:0][31:0] ctrl_d;
    logic [NUM_REGS-2:0]       wr_strobe_q, wr_strobe_d;
    logic [31:0]               status_d;

    logic [31:0]     off, widx, wdat, rdat, rd_snap, clr;
    logic            in_win, hit;
    bridge_reg_idx_t ridx;

`ifdef BRIDGE_REG_RESPONDER_ERR_COUNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;
`endif

    always_comb begin
        req_wr_d     = bridge_wr;
        req_rd_d     = bridge_rd;
        req_addr_d   = bridge_addr;
        req_data_d   = bridge_wr_data;
        req_le_d     = bridge_endian_little;
        status_set_d = status_set;
    end

    always_comb begin
        off    = req_addr_q - BASE_ADDR;
        in_win = (req_addr_q >= BASE_ADDR) && (off < WIN_BYTES);
        hit    = in_win && (off[1:0] == 2'b00);
        widx   = off >> 2;
        ridx   = bridge_reg_idx_t'(widx);
        wdat   = req_le_q ? req_data_q : bswap32(req_data_q);

        ctrl_d      = ctrl_q;
        wr_strobe_d = '0;
        rdat        = '0;
        clr         = '0;

        if (hit) begin
            for (int i = 0; i < NUM_REGS-1; i++) begin
                if (widx < 32'(NUM_REGS-1) && ridx == bridge_reg_idx_t'(i)) begin
                    rdat = ctrl_q[i];
                    if (req_wr_q) begin
                        ctrl_d[i]      = wdat;
                        wr_strobe_d[i] = 1'b1;
                    end
                end
            end
            if (widx == 32'(NUM_REGS-1)) begin
                rdat = status_q;
                if (req_wr_q) clr = wdat;
            end
        end

        status_d = (status_q & ~clr) | status_set_q;

`ifdef BRIDGE_REG_RESPONDER_ERR_COUNT_EN
        err_cnt_d = err_cnt_q;
        if ((req_rd_q || req_wr_q) && in_win && (off[1:0] != 2'b00) && (err_cnt_q != 8'hFF))
            err_cnt_d = err_cnt_q + 8'd1;
        if (hit && widx == 32'(NUM_REGS)) begin
            rdat = {24'h0, err_cnt_q};
            if (req_wr_q) err_cnt_d = '0;
        end
`endif

        // Snapshot is taken before this edge's write lands: read sees old data.
        rd_snap = req_le_q ? rdat : bswap32(rdat);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_wr_q     <= 1'b0;
            req_rd_q     <= 1'b0;
            req_addr_q   <= '0;
            req_data_q   <= '0;
            req_le_q     <= 1'b1;
            status_set_q <= '0;
            ctrl_q       <= {(NUM_REGS-1){CTRL_RESET}};
            wr_strobe_q  <= '0;
            status_q     <= '0;
        end else begin
            req_wr_q     <= req_wr_d;
            req_rd_q     <= req_rd_d;
            req_addr_q   <= req_addr_d;
            req_data_q   <= req_data_d;
            req_le_q     <= req_le_d;
            status_set_q <= status_set_d;
            ctrl_q       <= ctrl_d;
            wr_strobe_q  <= wr_strobe_d;
            status_q     <= status_d;
        end
    end

`ifdef BRIDGE_REG_RESPONDER_ERR_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset) err_cnt_q <= '0;
        else       err_cnt_q <= err_cnt_d;
    end
`endif

    assign wr_strobe = wr_strobe_q;

    bridge_rd_pipe #(
        .LATENCY (READ_LATENCY)
    ) u_rd_pipe (
        .clk     (clk),
        .reset   (reset),
        .in_vld  (req_rd_q),
        .in_data (rd_snap),
        .rd_data (bridge_rd_data)
    );

endmodule

// File: doc/bridge_reg_responder.md
Name: bridge_reg_responder

Overview:
- Slave (responder) end of bridge_if: terminates APF bridge accesses from the master.
- Decodes one word-aligned address window onto a bank of 32-bit registers with fixed-latency read return.
- Exposes RW control registers plus write strobes to the core, and one W1C sticky status register fed by core event pulses.
- Sits in the core top beside other bridge slaves; rd_data is zero on miss so slave outputs can be OR-combined.

Parameters:
- BASE_ADDR, 32'h0000_0000: byte address of register 0; must be 4-byte aligned.
- NUM_REGS, 8: total registers, 2..64. Registers 0..NUM_REGS-2 are RW control; register NUM_REGS-1 is W1C status.
- READ_LATENCY, 1: cycles from rd sample to rd_data update, 1..4.
- CTRL_RESET, 32'h0000_0000: reset value of every control register.

Ports:
- clk  input  1: bridge clock; all logic is on its rising edge.
- reset  input  1: synchronous, active-high.
- bridge  interface  bridge_if (slave end): inputs addr, wr_data, wr, rd, endian_little; output rd_data.
- ctrl_q  output  (NUM_REGS-1)x32: current control register values.
- wr_strobe  output  NUM_REGS-1: one-cycle pulse per control register, asserted in the cycle its ctrl_q updates.
- status_set  input  32: per-bit set pulses into the status register.
- status_q  output  32: current status register value.

Behaviour:
- Reset values: ctrl_q = CTRL_RESET; status_q = 0; wr_strobe = 0; rd_data = 0; read pipe cleared.
- Hit: BASE_ADDR <= addr < BASE_ADDR + 4*NUM_REGS, and addr[1:0] == 0.
- Index: idx = (addr - BASE_ADDR) >> 2, computed at 32-bit width.
- Endian: when endian_little = 0, wr_data is byte-swapped before use and rd_data is byte-swapped on output. endian_little is sampled in the same cycle as wr/rd.
- Write: wr high and hit, sampled at edge N, takes effect at edge N+1.
  - idx < NUM_REGS-1: ctrl_q[idx] loads the (swapped) data; wr_strobe[idx] is high for exactly that one cycle.
  - idx == NUM_REGS-1: status_q clears the bits written as 1.
- Status set: status_q |= status_set every cycle. A simultaneous set and W1C clear on the same bit leaves the bit set (set wins).
- Read: rd high sampled at edge N. rd_data updates at edge N+READ_LATENCY with the value of the addressed register as it stood before edge N+1 (pre-write snapshot).
  - rd_data holds until the next read completes.
  - Miss or misaligned read loads rd_data = 0.
- Back-to-back reads (rd on consecutive cycles) are fully pipelined: each completes in order, READ_LATENCY apart from its own issue.
- wr and rd in the same cycle: both are performed; the read returns the old value.
- Misaligned or out-of-range writes are ignored, with no strobe.
- wr and rd are treated as level samples per cycle. The master guarantees single-cycle pulses; a two-cycle wr pulse therefore writes twice and produces two strobes.
- Reset mid-operation: pending reads are discarded and rd_data = 0 on the cycle after reset; there is no late completion.

Optional Feature:
- Macro: BRIDGE_REG_RESPONDER_ERR_COUNT_EN.
- Defined:
  - An 8-bit saturating counter (sticks at 255) counts misaligned accesses, rd or wr, whose address lies in the window.
  - The counter is readable at BASE_ADDR + 4*NUM_REGS, which extends the hit window by one word.
  - Any write to that word clears the counter.
  - Reset value is 0.
- Undefined: no counter, window unchanged, and that address is a miss.

Decomposition:
- Package pocket gains:
  - constant BRIDGE_WORD_BYTES = 4;
  - function bswap32 (byte swap);
  - typedef bridge_reg_idx_t, a 6-bit register index.
- Sub-module bridge_rd_pipe: a READ_LATENCY-deep valid+data delay line with synchronous clear; it drives rd_data.

Test Plan:
- Reset then read:
  - Read every register with endian_little=1 and CTRL_RESET=32'hA5A5_0000 -> each control register returns 32'hA5A5_0000 at latency READ_LATENCY; status returns 0.
- Write and read back, big-endian:
  - Write 32'h1122_3344 to BASE+4 with endian_little=0 -> ctrl_q[1] = 32'h4433_2211; wr_strobe[1] pulses for one cycle.
  - Readback with endian_little=0 -> rd_data = 32'h1122_3344.
- Status set/clear race:
  - status_set = 32'h0000_0005 -> status_q = 5.
  - In one cycle, write 32'h0000_0005 to the status register while status_set = 32'h0000_0001 -> status_q = 1.
- Pipelined reads:
  - READ_LATENCY=3; rd on 4 consecutive cycles to regs 0..3 -> rd_data steps through the 4 values on 4 consecutive cycles, starting 3 cycles after the first rd.
- Misses:
  - Read BASE+2 (misaligned) and BASE+4*NUM_REGS -> rd_data = 0.
  - Write BASE+4*NUM_REGS -> no strobe, no change.
  - With the macro defined, 300 misaligned hits -> counter reads 255.
- Reset mid-read:
  - Issue rd, assert reset one cycle later -> rd_data = 0 afterwards; no stale completion.
